vc_fifo_bank: RTL and testbench
===============================

Name: vc_fifo_bank

Overview:
Parametrised bank of NUM_VC independent virtual-channel FIFOs. It replaces the per-channel single-VC FIFOs in the PCIe transmit-layer datapath. Each channel provides:
- programmable almost-full and almost-empty thresholds, latched on init
- a registered read port and a show-ahead head-of-queue port for the arbiter
- sticky overflow and underflow error flags

Parameters:
DATA_W, 6, width of one FIFO word
ADDR_W, 4, pointer width; depth DEPTH = 2**ADDR_W
NUM_VC, 2, number of virtual channels (>=1)
CNT_W, ADDR_W+1, occupancy counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
init  in  1  synchronous soft clear, and threshold latch
umbral_af  in  NUM_VC*CNT_W  per-VC almost-full threshold (slice v = bits [v*CNT_W +: CNT_W])
umbral_ae  in  NUM_VC*CNT_W  per-VC almost-empty threshold
wr_en  in  NUM_VC  per-VC write request
data_in  in  NUM_VC*DATA_W  per-VC write data
rd_en  in  NUM_VC  per-VC read request
data_out  out  NUM_VC*DATA_W  registered read data
valid_out  out  NUM_VC  data_out slice valid this cycle
head_data  out  NUM_VC*DATA_W  show-ahead mem[rd_ptr], combinational
full  out  NUM_VC  cnt == DEPTH
empty  out  NUM_VC  cnt == 0
almost_full  out  NUM_VC  cnt >= af_thr and cnt < DEPTH
almost_empty  out  NUM_VC  cnt <= ae_thr and cnt > 0
overflow_err  out  NUM_VC  sticky: write attempted while full and not accepted
underflow_err  out  NUM_VC  sticky: read attempted while empty

Behaviour:
Clock and reset (already decided):
- One clock, clk.
- reset is synchronous and active-high. It is sampled only on the rising edge of clk.

reset = 1, for all VCs:
- wr_ptr = 0, rd_ptr = 0, cnt = 0
- data_out = 0, valid_out = 0
- overflow_err = 0, underflow_err = 0
- af_thr = DEPTH-1, ae_thr = 1
- Memory contents are not cleared; no port exposes them while empty.

init = 1 (reset = 0) has the same effect as reset, except:
- af_thr and ae_thr load from umbral_af and umbral_ae.
- Thresholds are not sampled at any other time.

Flags:
- full, empty, almost_full and almost_empty are combinational from the registered cnt and thresholds. They are valid in the same cycle as cnt.
- While reset or init is asserted they are forced: empty = 1, all others 0.

Per-VC operation each cycle (reset = 0, init = 0):
- Write accepted (wa) = wr_en & (~full | rd_en). A write on a full FIFO succeeds when a read occurs in the same cycle.
- Read accepted (ra) = rd_en & ~empty.
- On wa: mem[wr_ptr] <= data_in slice; wr_ptr increments.
- On ra: data_out <= mem[rd_ptr]; valid_out <= 1; rd_ptr increments.
- Otherwise: valid_out <= 0, and data_out holds its value.
- Read latency is 1 cycle.
- Same-cycle write and read on an empty FIFO: only the write is accepted. No write-through.
- cnt update: cnt+1 if wa & ~ra; cnt-1 if ra & ~wa; unchanged otherwise. cnt never exceeds DEPTH and never goes below 0.
- Pointers wrap modulo DEPTH through natural ADDR_W overflow.
- overflow_err <= 1 if wr_en & full & ~rd_en.
- underflow_err <= 1 if rd_en & empty.
- Both error flags stay set until reset or init.
- head_data = mem[rd_ptr] at all times. It is meaningful only when ~empty.

Thresholds:
- Threshold values >= DEPTH are legal. Flags then follow the formulas: almost_full never asserts, and almost_empty equals ~empty.

Channel independence:
- Channels share no state. Any VC can be read and written in the same cycle as any other VC.

Decomposition:
- Package vc_fifo_pkg holds:
  - function clog2
  - DEPTH/CNT_W derivation helpers
  - reset-default threshold constants AF_DEFAULT and AE_DEFAULT, as functions of DEPTH
- Sub-module vc_fifo_core: one channel with scalar ports. It holds the memory, pointers, counter, flags and errors.
- vc_fifo_bank instantiates NUM_VC copies of vc_fifo_core in a generate loop and slices the flattened buses.

Test Plan:
1. Defaults; init with umbral_af = 12, umbral_ae = 3; write 0x01..0x10 on VC0 only.
   -> almost_empty[0] at cnt 1–3; almost_full[0] at cnt 12–15; full[0] after the 16th write.
   -> VC1 stays empty = 1 throughout.
2. VC0 full; pulse wr_en alone with data 0x2A.
   -> Write dropped; overflow_err[0] = 1 and stays set; cnt stays 16.
   -> Then rd_en and wr_en together: data_out = 0x01 next cycle with valid_out; cnt stays 16; 0x2A stored at the tail.
3. Empty VC1; rd_en = 1.
   -> underflow_err[1] = 1; valid_out[1] = 0; cnt stays 0.
   -> Same-cycle wr_en + rd_en on empty with 0x15: cnt = 1, valid_out = 0, head_data[1] = 0x15.
4. Wrap-around: 40 cycles of interleaved writes and reads on VC0 at 1/cycle after one pre-fill word.
   -> data_out order matches input order; cnt stays 1; pointers wrap past 15 cleanly.
5. Reset mid-operation with VC0 at cnt 9 and error set.
   -> Next cycle: cnt 0, empty = 1, errors 0, valid_out = 0, thresholds back to AF = 15 and AE = 1.
   -> Assert init with new thresholds: they take effect immediately.
6. Concurrency: both VCs streaming simultaneous writes and reads for 100 random cycles against a reference queue.
   -> Zero mismatches; flags consistent with model cnt every cycle.

Source files
------------

// File: rtl/vc_fifo_pkg.sv
// Shared helpers and constants for the virtual-channel FIFO bank.
// Sizing functions, reset-default thresholds and the counter update encoding.
package vc_fifo_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // One extra bit so the counter can represent a completely full FIFO.
  function automatic int unsigned cnt_w_of(input int unsigned addr_w);
    return clog2(depth_of(addr_w)) + 1;
  endfunction

  function automatic int unsigned AF_DEFAULT(input int unsigned depth);
    return depth - 1;
  endfunction

  function automatic int unsigned AE_DEFAULT(input int unsigned depth);
    return (depth > 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/vc_fifo_core.sv
// Single virtual-channel FIFO: memory, pointers, occupancy counter,
// programmable almost flags, registered read port and sticky error flags.
module vc_fifo_core
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 4,
  localparam int unsigned CNT_W = cnt_w_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_init,
  input  logic [CNT_W-1:0]  i_umbral_af,
  input  logic [CNT_W-1:0]  i_umbral_ae,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic              o_overflow_err,
  output logic              o_underflow_err
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_af_thr;
  logic [CNT_W-1:0]  r_ae_thr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ovf;
  logic              r_unf;

  logic    w_clear;
  logic    w_full;
  logic    w_empty;
  logic    w_wa;
  logic    w_ra;
  cnt_op_e w_op;

  assign w_clear = i_reset | i_init;
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_empty = (r_cnt == '0);
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign w_wa    = i_wr_en & (~w_full | i_rd_en);
  assign w_ra    = i_rd_en & ~w_empty;

  always_comb begin
    w_op = CNT_HOLD;
    if (w_wa && !w_ra)      w_op = CNT_INC;
    else if (w_ra && !w_wa) w_op = CNT_DEC;
  end

  always_ff @(posedge clk) begin
    if (!w_clear && w_wa) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_af_thr <= i_reset ? CNT_W'(AF_DEFAULT(DEPTH)) : i_umbral_af;
      r_ae_thr <= i_reset ? CNT_W'(AE_DEFAULT(DEPTH)) : i_umbral_ae;
    end else begin
      if (w_wa) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_ra) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_valid <= w_ra;
      case (w_op)
        CNT_INC: r_cnt <= r_cnt + CNT_W'(1);
        CNT_DEC: r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (i_wr_en && w_full && !i_rd_en) r_ovf <= 1'b1;
      if (i_rd_en && w_empty)            r_unf <= 1'b1;
    end
  end

  assign o_data          = r_data;
  assign o_valid         = r_valid;
  assign o_head          = r_mem[r_rd_ptr];
  assign o_overflow_err  = r_ovf;
  assign o_underflow_err = r_unf;
  assign o_full          = ~w_clear & w_full;
  assign o_empty         = w_clear | w_empty;
  assign o_almost_full   = ~w_clear & (r_cnt >= r_af_thr) & ~w_full;
  assign o_almost_empty  = ~w_clear & (r_cnt <= r_ae_thr) & ~w_empty;

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent virtual-channel FIFOs sharing only the clock,
// reset and init; per-channel signals are slices of flattened buses.
module vc_fifo_bank
  import vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NUM_VC = 2,
  localparam int unsigned CNT_W = cnt_w_of(ADDR_W)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [NUM_VC*CNT_W-1:0]    umbral_af,
  input  logic [NUM_VC*CNT_W-1:0]    umbral_ae,
  input  logic [NUM_VC-1:0]          wr_en,
  input  logic [NUM_VC*DATA_W-1:0]   data_in,
  input  logic [NUM_VC-1:0]          rd_en,
  output logic [NUM_VC*DATA_W-1:0]   data_out,
  output logic [NUM_VC-1:0]          valid_out,
  output logic [NUM_VC*DATA_W-1:0]   head_data,
  output logic [NUM_VC-1:0]          full,
  output logic [NUM_VC-1:0]          empty,
  output logic [NUM_VC-1:0]          almost_full,
  output logic [NUM_VC-1:0]          almost_empty,
  output logic [NUM_VC-1:0]          overflow_err,
  output logic [NUM_VC-1:0]          underflow_err
);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo_core #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_core (
      .clk            (clk),
      .i_reset        (reset),
      .i_init         (init),
      .i_umbral_af    (umbral_af[v*CNT_W +: CNT_W]),
      .i_umbral_ae    (umbral_ae[v*CNT_W +: CNT_W]),
      .i_wr_en        (wr_en[v]),
      .i_data         (data_in[v*DATA_W +: DATA_W]),
      .i_rd_en        (rd_en[v]),
      .o_data         (data_out[v*DATA_W +: DATA_W]),
      .o_valid        (valid_out[v]),
      .o_head         (head_data[v*DATA_W +: DATA_W]),
      .o_full         (full[v]),
      .o_empty        (empty[v]),
      .o_almost_full  (almost_full[v]),
      .o_almost_empty (almost_empty[v]),
      .o_overflow_err (overflow_err[v]),
      .o_underflow_err(underflow_err[v])
    );
  end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Self-checking bench for vc_fifo_bank: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_vc_fifo_bank;

  localparam int DATA_W = 6;
  localparam int ADDR_W = 4;
  localparam int NUM_VC = 2;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     init;
  logic [NUM_VC*CNT_W-1:0]  umbral_af;
  logic [NUM_VC*CNT_W-1:0]  umbral_ae;
  logic [NUM_VC-1:0]        wr_en;
  logic [NUM_VC*DATA_W-1:0] data_in;
  logic [NUM_VC-1:0]        rd_en;
  logic [NUM_VC*DATA_W-1:0] data_out;
  logic [NUM_VC-1:0]        valid_out;
  logic [NUM_VC*DATA_W-1:0] head_data;
  logic [NUM_VC-1:0]        full;
  logic [NUM_VC-1:0]        empty;
  logic [NUM_VC-1:0]        almost_full;
  logic [NUM_VC-1:0]        almost_empty;
  logic [NUM_VC-1:0]        overflow_err;
  logic [NUM_VC-1:0]        underflow_err;

  vc_fifo_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_VC(NUM_VC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_af    (umbral_af),
    .umbral_ae    (umbral_ae),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .head_data    (head_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel plus the observable registers.
  logic [DATA_W-1:0] mq [NUM_VC][$];
  int                m_af   [NUM_VC];
  int                m_ae   [NUM_VC];
  logic [DATA_W-1:0] m_dout [NUM_VC];
  bit                m_vout [NUM_VC];
  bit                m_ovf  [NUM_VC];
  bit                m_unf  [NUM_VC];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int v = 0; v < NUM_VC; v++) begin
      if (reset || init) begin
        mq[v].delete();
        m_dout[v] = '0;
        m_vout[v] = 0;
        m_ovf[v]  = 0;
        m_unf[v]  = 0;
        m_af[v]   = reset ? DEPTH - 1 : int'(umbral_af[v*CNT_W +: CNT_W]);
        m_ae[v]   = reset ? 1 : int'(umbral_ae[v*CNT_W +: CNT_W]);
      end else begin
        bit is_full, is_empty, wa, ra;
        is_full  = (mq[v].size() == DEPTH);
        is_empty = (mq[v].size() == 0);
        wa = wr_en[v] && (!is_full || rd_en[v]);
        ra = rd_en[v] && !is_empty;
        if (wr_en[v] && is_full && !rd_en[v]) m_ovf[v] = 1;
        if (rd_en[v] && is_empty)             m_unf[v] = 1;
        m_vout[v] = ra;
        if (ra) m_dout[v] = mq[v].pop_front();
        if (wa) mq[v].push_back(data_in[v*DATA_W +: DATA_W]);
      end
    end
  endtask

  task automatic check_all();
    for (int v = 0; v < NUM_VC; v++) begin
      int  n;
      bit  clr;
      n   = mq[v].size();
      clr = reset || init;
      check($sformatf("vc%0d_empty", v), 32'(empty[v]), 32'(clr || n == 0));
      check($sformatf("vc%0d_full", v), 32'(full[v]), 32'(!clr && n == DEPTH));
      check($sformatf("vc%0d_afull", v), 32'(almost_full[v]),
            32'(!clr && n >= m_af[v] && n < DEPTH));
      check($sformatf("vc%0d_aempty", v), 32'(almost_empty[v]),
            32'(!clr && n <= m_ae[v] && n > 0));
      check($sformatf("vc%0d_valid", v), 32'(valid_out[v]), 32'(m_vout[v]));
      check($sformatf("vc%0d_dout", v), 32'(data_out[v*DATA_W +: DATA_W]), 32'(m_dout[v]));
      check($sformatf("vc%0d_ovf", v), 32'(overflow_err[v]), 32'(m_ovf[v]));
      check($sformatf("vc%0d_unf", v), 32'(underflow_err[v]), 32'(m_unf[v]));
      if (!clr && n > 0)
        check($sformatf("vc%0d_head", v), 32'(head_data[v*DATA_W +: DATA_W]), 32'(mq[v][0]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle();
    wr_en = '0;
    rd_en = '0;
    init  = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; wr_en = '0; rd_en = '0; data_in = '0;
    umbral_af = {5'd12, 5'd12};
    umbral_ae = {5'd3, 5'd3};
    step();
    step();
    check("reset_empty", 32'(empty), 32'h3);
    check("reset_valid", 32'(valid_out), 32'h0);

    // 1: init with thresholds 12/3, fill VC0 with 0x01..0x10
    reset = 1'b0; init = 1'b1;
    step();
    idle();
    for (int i = 1; i <= DEPTH; i++) begin
      wr_en = 2'b01;
      data_in[5:0] = 6'(i);
      step();
      check("t1_aempty", 32'(almost_empty[0]), 32'(i <= 3));
      check("t1_afull", 32'(almost_full[0]), 32'(i >= 12 && i <= 15));
      check("t1_full", 32'(full[0]), 32'(i == 16));
      check("t1_vc1_empty", 32'(empty[1]), 32'h1);
    end

    // 2: overflow attempt, then simultaneous read+write on full FIFO
    wr_en = 2'b01; data_in[5:0] = 6'h2A;
    step();
    check("t2_ovf", 32'(overflow_err[0]), 32'h1);
    idle();
    step();
    check("t2_ovf_sticky", 32'(overflow_err[0]), 32'h1);
    check("t2_full_kept", 32'(full[0]), 32'h1);
    wr_en = 2'b01; rd_en = 2'b01; data_in[5:0] = 6'h2A;
    step();
    check("t2_dout", 32'(data_out[5:0]), 32'h01);
    check("t2_valid", 32'(valid_out[0]), 32'h1);
    check("t2_still_full", 32'(full[0]), 32'h1);
    idle();

    // 3: underflow on empty VC1, then same-cycle write+read on empty
    rd_en = 2'b10;
    step();
    check("t3_unf", 32'(underflow_err[1]), 32'h1);
    check("t3_valid", 32'(valid_out[1]), 32'h0);
    wr_en = 2'b10; rd_en = 2'b10; data_in[11:6] = 6'h15;
    step();
    check("t3_wr_valid", 32'(valid_out[1]), 32'h0);
    check("t3_head", 32'(head_data[11:6]), 32'h15);
    idle();

    // 4: pre-fill one word then 40 cycles of simultaneous write/read on VC0
    init = 1'b1;
    step();
    idle();
    wr_en = 2'b01; data_in[5:0] = 6'h3F;
    step();
    for (int i = 0; i < 40; i++) begin
      wr_en = 2'b01; rd_en = 2'b01;
      data_in[5:0] = 6'($urandom);
      step();
      check("t4_one_left", 32'(almost_empty[0] && !empty[0]), 32'h1);
    end
    idle();

    // 5: reset mid-operation with VC0 holding 9 words and an error set
    init = 1'b1;
    step();
    idle();
    rd_en = 2'b01;
    step();
    idle();
    for (int i = 0; i < 9; i++) begin
      wr_en = 2'b01; data_in[5:0] = 6'($urandom);
      step();
    end
    idle();
    reset = 1'b1;
    step();
    idle();
    step();
    check("t5_empty", 32'(empty[0]), 32'h1);
    check("t5_unf_clr", 32'(underflow_err[0]), 32'h0);
    for (int i = 1; i <= 15; i++) begin
      wr_en = 2'b01; data_in[5:0] = 6'($urandom);
      step();
    end
    check("t5_af_default", 32'(almost_full[0]), 32'h1);
    umbral_af = {5'd20, 5'd4};
    umbral_ae = {5'd20, 5'd2};
    init = 1'b1; wr_en = '0;
    step();
    idle();
    for (int i = 1; i <= 4; i++) begin
      wr_en = 2'b11; data_in = 12'($urandom);
      step();
    end
    idle();
    check("t5_af_new", 32'(almost_full[0]), 32'h1);
    check("t5_vc1_ae_big", 32'(almost_empty[1]), 32'h1);
    check("t5_vc1_af_big", 32'(almost_full[1]), 32'h0);

    // 6: random concurrent traffic on both channels
    for (int i = 0; i < 100; i++) begin
      wr_en   = 2'($urandom);
      rd_en   = 2'($urandom);
      data_in = 12'($urandom);
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout reached before end of stimulus");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
